// File: rtl/counter_checker_pkg.sv
// -----------------------------------------------------------------------------
// counter_checker_pkg
//   Shared constants and types for the counter checker family.
//   The fire vector layout is fixed here, so every checker and every consumer
//   of a fire vector agrees on which bit means which rule.
// -----------------------------------------------------------------------------
package counter_checker_pkg;

  // Fire bit positions.
  localparam int CHK_OVF        = 0;  // overflow
  localparam int CHK_UNF        = 1;  // underflow
  localparam int CHK_MIS        = 2;  // model mismatch
  localparam int CHK_FIRE_WIDTH = 3;

  typedef logic [CHK_FIRE_WIDTH-1:0] chk_fire_t;

endpackage : counter_checker_pkg

// File: rtl/counter_chk_model.sv
// -----------------------------------------------------------------------------
// counter_chk_model
//   Combinational next-value predictor for a loadable up/down counter.
//   Priority: load, then increment-only, then decrement-only, else hold.
//   Arithmetic wraps modulo 2^WIDTH.
//
// Ports
//   data_out_i  observed counter value this cycle
//   data_in_i   load value
//   ld_i        load strobe
//   inc_i       increment strobe
//   dec_i       decrement strobe (treated as 0 when UP_DOWN=0)
//   next_o      predicted counter value for the next cycle
// -----------------------------------------------------------------------------
module counter_chk_model #(
  parameter int WIDTH   = 3,
  parameter bit UP_DOWN = 1'b0
) (
  input  logic [WIDTH-1:0] data_out_i,
  input  logic [WIDTH-1:0] data_in_i,
  input  logic             ld_i,
  input  logic             inc_i,
  input  logic             dec_i,
  output logic [WIDTH-1:0] next_o
);

  logic dec_eff;

  assign dec_eff = UP_DOWN ? dec_i : 1'b0;

  always_comb begin
    // NOTE: default assigned first so no path leaves next_o unassigned; this
    // is what keeps a combinational block from inferring a latch.
    next_o = data_out_i;
    if (ld_i) begin
      next_o = data_in_i;
    end else if (inc_i && !dec_eff) begin
      next_o = data_out_i + WIDTH'(1);
    end else if (dec_eff && !inc_i) begin
      next_o = data_out_i - WIDTH'(1);
    end
  end

endmodule : counter_chk_model

// File: rtl/counter_checker.sv
// -----------------------------------------------------------------------------
// counter_checker
//   Passive checker placed beside a loadable up/down counter. Predicts the
//   counter's next value from what it observes this cycle and flags overflow,
//   underflow and mismatch. Violation status is kept as a sticky flag, a
//   saturating count, and the fire vector of the first violating cycle.
//   Nothing here feeds back into the observed datapath.
//
// Ports
//   clk         clock
//   rst         synchronous active-high reset
//   enable      checking enabled; 0 ignores all rules
//   ld/inc/dec  counter control strobes (dec ignored when UP_DOWN=0)
//   data_in     counter load value
//   data_out    observed counter value
//   fire        registered per-rule pulse: [0] ovf, [1] unf, [2] mismatch
//   err_sticky  any violation since reset
//   err_count   violating cycles since reset, saturating
//   first_err   fire vector of the first violating cycle
// -----------------------------------------------------------------------------
module counter_checker
  import counter_checker_pkg::*;
#(
  parameter int    WIDTH         = 3,
  parameter bit    UP_DOWN       = 1'b0,
  parameter bit    WRAP_ALLOWED  = 1'b0,
  parameter int    RESET_VAL     = 0,
  parameter int    ERR_CNT_WIDTH = 8,
  parameter string MSG           = "Counter Violation"
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      enable,
  input  logic                      ld,
  input  logic                      inc,
  input  logic                      dec,
  input  logic [WIDTH-1:0]          data_in,
  input  logic [WIDTH-1:0]          data_out,
  output logic [CHK_FIRE_WIDTH-1:0] fire,
  output logic                      err_sticky,
  output logic [ERR_CNT_WIDTH-1:0]  err_count,
  output logic [CHK_FIRE_WIDTH-1:0] first_err
);

  chk_fire_t                fire_d, fire_q;
  chk_fire_t                first_err_d, first_err_q;
  logic [WIDTH-1:0]         exp_d, exp_q;
  logic                     exp_valid_d, exp_valid_q;
  logic                     err_sticky_d, err_sticky_q;
  logic [ERR_CNT_WIDTH-1:0] err_count_d, err_count_q;
  logic [WIDTH-1:0]         model_next;
  logic                     dec_eff;
  logic                     active;

  assign dec_eff = UP_DOWN ? dec : 1'b0;
  assign active  = enable && !rst;

  // The prediction is seeded from the observed value, not from exp_q, so a
  // single corrupted sample yields exactly one mismatch.
  counter_chk_model #(
    .WIDTH   (WIDTH),
    .UP_DOWN (UP_DOWN)
  ) u_model (
    .data_out_i (data_out),
    .data_in_i  (data_in),
    .ld_i       (ld),
    .inc_i      (inc),
    .dec_i      (dec),
    .next_o     (model_next)
  );

  always_comb begin
    fire_d               = '0;
    fire_d[CHK_OVF]      = active && !WRAP_ALLOWED && !ld && inc && !dec_eff
                           && (data_out == {WIDTH{1'b1}});
    fire_d[CHK_UNF]      = active && UP_DOWN && !WRAP_ALLOWED && !ld && dec_eff
                           && !inc && (data_out == '0);
    fire_d[CHK_MIS]      = active && exp_valid_q && (data_out != exp_q);

    exp_d        = model_next;
    // A disabled cycle breaks the chain of observations, so the first enabled
    // cycle afterwards only re-seeds the model and is not checked.
    exp_valid_d  = enable;

    err_count_d  = err_count_q;
    if ((fire_d != '0) && (err_count_q != {ERR_CNT_WIDTH{1'b1}})) begin
      err_count_d = err_count_q + ERR_CNT_WIDTH'(1);
    end

    err_sticky_d = err_sticky_q || (fire_d != '0);
    first_err_d  = (!err_sticky_q && (fire_d != '0)) ? fire_d : first_err_q;
  end

  always_ff @(posedge clk) begin
    // NOTE: reset is synchronous, so it lives inside the clocked branch and
    // is not in the sensitivity list.
    if (rst) begin
      fire_q       <= '0;
      exp_q        <= WIDTH'(RESET_VAL);
      exp_valid_q  <= 1'b1;
      err_sticky_q <= 1'b0;
      err_count_q  <= '0;
      first_err_q  <= '0;
    end else begin
      // NOTE: non-blocking assignments for all state so every register
      // samples the pre-edge values regardless of statement order.
      fire_q       <= fire_d;
      exp_q        <= exp_d;
      exp_valid_q  <= exp_valid_d;
      err_sticky_q <= err_sticky_d;
      err_count_q  <= err_count_d;
      first_err_q  <= first_err_d;
    end
  end

  assign fire       = fire_q;
  assign err_sticky = err_sticky_q;
  assign err_count  = err_count_q;
  assign first_err  = first_err_q;

`ifndef SYNTHESIS
  // Reported at the edge that launches the fire pulse, while data_out and
  // exp_q still hold the values that caused it.
  always_ff @(posedge clk) begin
    if (fire_d[CHK_OVF])
      $display("%s: overflow at %0t data_out=%0d exp_q=%0d", MSG, $time, data_out, exp_q);
    if (fire_d[CHK_UNF])
      $display("%s: underflow at %0t data_out=%0d exp_q=%0d", MSG, $time, data_out, exp_q);
    if (fire_d[CHK_MIS])
      $display("%s: mismatch at %0t data_out=%0d exp_q=%0d", MSG, $time, data_out, exp_q);
  end
`endif

endmodule : counter_checker

// File: tb/tb_counter_checker.sv
// -----------------------------------------------------------------------------
// tb_counter_checker
//   Four checker instances share one stimulus bus:
//     A: defaults            W: WRAP_ALLOWED=1
//     U: UP_DOWN=1           S: ERR_CNT_WIDTH=2
//   Each vector names the instance whose response it predicts; the expected
//   response is queued, and a monitor pops and compares one cycle later.
// -----------------------------------------------------------------------------
module tb_counter_checker;

  localparam int SEL_A = 0;
  localparam int SEL_W = 1;
  localparam int SEL_U = 2;
  localparam int SEL_S = 3;

  logic       clk = 1'b0;
  logic       rst, enable, ld, inc, dec;
  logic [2:0] data_in, data_out;

  logic [2:0] fire_a, fire_w, fire_u, fire_s;
  logic [2:0] first_a, first_w, first_u, first_s;
  logic       sticky_a, sticky_w, sticky_u, sticky_s;
  logic [7:0] cnt_a, cnt_w, cnt_u;
  logic [1:0] cnt_s;

  typedef struct {
    int         sel;
    string      tag;
    logic [2:0] fire;
    logic [7:0] cnt;
    logic       sticky;
    logic [2:0] first;
  } exp_t;

  exp_t sb_q[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  always #5 clk = ~clk;

  counter_checker dut_a (
    .clk(clk), .rst(rst), .enable(enable), .ld(ld), .inc(inc), .dec(dec),
    .data_in(data_in), .data_out(data_out), .fire(fire_a),
    .err_sticky(sticky_a), .err_count(cnt_a), .first_err(first_a));

  counter_checker #(.WRAP_ALLOWED(1'b1)) dut_w (
    .clk(clk), .rst(rst), .enable(enable), .ld(ld), .inc(inc), .dec(dec),
    .data_in(data_in), .data_out(data_out), .fire(fire_w),
    .err_sticky(sticky_w), .err_count(cnt_w), .first_err(first_w));

  counter_checker #(.UP_DOWN(1'b1)) dut_u (
    .clk(clk), .rst(rst), .enable(enable), .ld(ld), .inc(inc), .dec(dec),
    .data_in(data_in), .data_out(data_out), .fire(fire_u),
    .err_sticky(sticky_u), .err_count(cnt_u), .first_err(first_u));

  counter_checker #(.ERR_CNT_WIDTH(2)) dut_s (
    .clk(clk), .rst(rst), .enable(enable), .ld(ld), .inc(inc), .dec(dec),
    .data_in(data_in), .data_out(data_out), .fire(fire_s),
    .err_sticky(sticky_s), .err_count(cnt_s), .first_err(first_s));

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: actual=%0h required=%0h", name, act, req);
    end
  endtask

  // Applies one cycle of stimulus and queues the response expected after the
  // following clock edge. Sticky is implied by a non-zero expected count.
  task automatic vec(input int sel, input string tag,
                     input logic r, input logic en, input logic l,
                     input logic i, input logic d,
                     input logic [2:0] din, input logic [2:0] dout,
                     input logic [2:0] efire, input logic [7:0] ecnt,
                     input logic [2:0] efirst);
    exp_t e;
    @(negedge clk);
    rst      = r;
    enable   = en;
    ld       = l;
    inc      = i;
    dec      = d;
    data_in  = din;
    data_out = dout;
    e.sel    = sel;
    e.tag    = tag;
    e.fire   = efire;
    e.cnt    = ecnt;
    e.sticky = (ecnt != 8'd0);
    e.first  = efirst;
    sb_q.push_back(e);
  endtask

  // Monitor: one queued expectation per clock edge.
  initial begin
    exp_t       e;
    logic [2:0] a_fire, a_first;
    logic [7:0] a_cnt;
    logic       a_sticky;
    forever begin
      @(posedge clk);
      #1;
      if (sb_q.size() > 0) begin
        e = sb_q.pop_front();
        case (e.sel)
          SEL_A:   begin a_fire = fire_a; a_cnt = cnt_a; a_sticky = sticky_a; a_first = first_a; end
          SEL_W:   begin a_fire = fire_w; a_cnt = cnt_w; a_sticky = sticky_w; a_first = first_w; end
          SEL_U:   begin a_fire = fire_u; a_cnt = cnt_u; a_sticky = sticky_u; a_first = first_u; end
          default: begin a_fire = fire_s; a_cnt = {6'd0, cnt_s}; a_sticky = sticky_s; a_first = first_s; end
        endcase
        check({e.tag, ".fire"},      {5'd0, a_fire},   {5'd0, e.fire});
        check({e.tag, ".err_count"}, a_cnt,            e.cnt);
        check({e.tag, ".err_sticky"},{7'd0, a_sticky}, {7'd0, e.sticky});
        check({e.tag, ".first_err"}, {5'd0, a_first},  {5'd0, e.first});
      end
    end
  end

  initial begin
    logic [2:0] ef;
    logic [7:0] ec;
    rst = 1'b1; enable = 1'b1; ld = 1'b0; inc = 1'b0; dec = 1'b0;
    data_in = 3'd0; data_out = 3'd0;

    // Incrementing through the 7->0 wrap: overflow once on A, silent on W.
    for (int s = SEL_A; s <= SEL_W; s++) begin
      vec(s, "wrap_rst", 1, 1, 0, 0, 0, 3'd0, 3'd0, 3'b000, 0, 3'b000);
      for (int k = 0; k < 9; k++) begin
        ef = (s == SEL_A && k == 7) ? 3'b001 : 3'b000;
        ec = (s == SEL_A && k >= 7) ? 8'd1 : 8'd0;
        vec(s, $sformatf("wrap%0d_k%0d", s, k), 0, 1, 0, 1, 0, 3'd0, 3'(k),
            ef, ec, (ec != 0) ? 3'b001 : 3'b000);
      end
    end

    // Load 5, counter shows 4: one mismatch, then clean; dec ignored on A.
    vec(SEL_A, "ld_rst",  1, 1, 0, 0, 0, 3'd0, 3'd0, 3'b000, 0, 3'b000);
    vec(SEL_A, "ld5",     0, 1, 1, 0, 0, 3'd5, 3'd0, 3'b000, 0, 3'b000);
    vec(SEL_A, "ld_bad4", 0, 1, 0, 1, 0, 3'd0, 3'd4, 3'b100, 1, 3'b100);
    vec(SEL_A, "ld_ok5",  0, 1, 0, 0, 0, 3'd0, 3'd5, 3'b000, 1, 3'b100);
    vec(SEL_A, "dec_ign", 0, 1, 0, 0, 1, 3'd0, 3'd5, 3'b000, 1, 3'b100);
    vec(SEL_A, "dec_ig2", 0, 1, 0, 0, 0, 3'd0, 3'd5, 3'b000, 1, 3'b100);

    // Up/down: underflow at 0, then inc&dec together holds 3.
    vec(SEL_U, "ud_rst",  1, 1, 0, 0, 0, 3'd0, 3'd0, 3'b000, 0, 3'b000);
    vec(SEL_U, "unf",     0, 1, 0, 0, 1, 3'd0, 3'd0, 3'b010, 1, 3'b010);
    vec(SEL_U, "ud_ld3",  0, 1, 1, 0, 0, 3'd3, 3'd7, 3'b000, 1, 3'b010);
    vec(SEL_U, "incdec",  0, 1, 0, 1, 1, 3'd0, 3'd3, 3'b000, 1, 3'b010);
    vec(SEL_U, "ud_hold", 0, 1, 0, 0, 0, 3'd0, 3'd3, 3'b000, 1, 3'b010);

    // Disabled cycles and the first re-enabled cycle are unchecked.
    vec(SEL_A, "en_rst",  1, 1, 0, 0, 0, 3'd0, 3'd0, 3'b000, 0, 3'b000);
    vec(SEL_A, "en_ok",   0, 1, 0, 0, 0, 3'd0, 3'd0, 3'b000, 0, 3'b000);
    vec(SEL_A, "dis1",    0, 0, 0, 0, 0, 3'd0, 3'd6, 3'b000, 0, 3'b000);
    vec(SEL_A, "dis2",    0, 0, 0, 0, 0, 3'd0, 3'd2, 3'b000, 0, 3'b000);
    vec(SEL_A, "reen1",   0, 1, 0, 0, 0, 3'd0, 3'd5, 3'b000, 0, 3'b000);
    vec(SEL_A, "reen2",   0, 1, 0, 0, 0, 3'd0, 3'd1, 3'b100, 1, 3'b100);

    // Saturation of a 2-bit counter, then reset mid-fault and re-seed.
    vec(SEL_S, "sat_rst", 1, 1, 0, 0, 0, 3'd0, 3'd0, 3'b000, 0, 3'b000);
    vec(SEL_S, "sat1",    0, 1, 0, 0, 0, 3'd0, 3'd1, 3'b100, 1, 3'b100);
    vec(SEL_S, "sat2",    0, 1, 0, 0, 0, 3'd0, 3'd2, 3'b100, 2, 3'b100);
    vec(SEL_S, "sat3",    0, 1, 0, 0, 0, 3'd0, 3'd3, 3'b100, 3, 3'b100);
    vec(SEL_S, "sat4",    0, 1, 0, 0, 0, 3'd0, 3'd4, 3'b100, 3, 3'b100);
    vec(SEL_S, "sat5",    0, 1, 0, 0, 0, 3'd0, 3'd5, 3'b100, 3, 3'b100);
    vec(SEL_S, "mid_rst", 1, 1, 0, 0, 0, 3'd0, 3'd5, 3'b000, 0, 3'b000);
    vec(SEL_S, "post_rst",0, 1, 0, 0, 0, 3'd0, 3'd2, 3'b100, 1, 3'b100);

    // Let the monitor consume the last expectation, then confirm it drained.
    @(negedge clk);
    @(posedge clk);
    #2;
    check("scoreboard_drained", 8'(sb_q.size()), 8'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule : tb_counter_checker
